// File: rtl/sm_register_file_sb.sv
// sm_register_file_sb: N-read/2-write register file with load busy scoreboard and PC slot.
// RF_BYPASS_EN: when defined, reads see this cycle's writes/busy updates combinationally.
module sm_register_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREAD  = 3,
    parameter int PC_REG = 15
) (
    input  logic                      clk,
    input  logic                      rst_p,
    input  logic [NREAD*ADDR_W-1:0]   read_adress,
    output logic [NREAD*DATA_W-1:0]   read_data,
    output logic [NREAD-1:0]          read_busy,
    input  logic                      wa_enable,
    input  logic [ADDR_W-1:0]         wa_adress,
    input  logic [DATA_W-1:0]         wa_data,
    input  logic                      wb_enable,
    input  logic [ADDR_W-1:0]         wb_adress,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      rsv_enable,
    input  logic [ADDR_W-1:0]         rsv_adress,
    input  logic [DATA_W-1:0]         r15,
    output logic                      wr_collision
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC = ADDR_W'(PC_REG);
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              coll_q, coll_d;
    logic              wa_ok, wb_ok, rsv_ok;

    assign wa_ok  = wa_enable && wa_adress != PC;
    assign wb_ok  = wb_enable && wb_adress != PC;
    assign rsv_ok = rsv_enable && rsv_adress != PC;
    assign coll_d = wa_ok && wb_ok && wa_adress == wb_adress;

    // B is applied after A so the load wins; reserve after clear so a new load stays busy
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wa_ok) regs_d[wa_adress] = wa_data;
        if (wb_ok) begin
            regs_d[wb_adress] = wb_data;
            busy_d[wb_adress] = 1'b0;
        end
        if (rsv_ok) busy_d[rsv_adress] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            coll_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            coll_q <= coll_d;
        end
    end

    assign wr_collision = coll_q;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = read_adress[i*ADDR_W +: ADDR_W];
        assign read_data[i*DATA_W +: DATA_W] = a == PC ? r15 : (BYP ? regs_d[a] : regs_q[a]);
        assign read_busy[i] = a != PC && (BYP ? busy_d[a] : busy_q[a]);
    end
endmodule

// File: tb/tb_sm_register_file_sb.sv
// tb_sm_register_file_sb: directed + random checks of the register file against an array model.
module tb_sm_register_file_sb;
    localparam int DW = 64, AW = 4, NR = 4, PC = 15;

    logic              clk = 1'b0;
    logic              rst_p;
    logic [NR*AW-1:0]  read_adress;
    logic [NR*DW-1:0]  read_data;
    logic [NR-1:0]     read_busy;
    logic              wa_enable, wb_enable, rsv_enable;
    logic [AW-1:0]     wa_adress, wb_adress, rsv_adress;
    logic [DW-1:0]     wa_data, wb_data, r15;
    logic              wr_collision;

    logic [DW-1:0]     mem [16];
    logic [15:0]       bsy;
    int                nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    sm_register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .PC_REG(PC)) dut (
        .clk(clk), .rst_p(rst_p), .read_adress(read_adress), .read_data(read_data),
        .read_busy(read_busy), .wa_enable(wa_enable), .wa_adress(wa_adress), .wa_data(wa_data),
        .wb_enable(wb_enable), .wb_adress(wb_adress), .wb_data(wb_data),
        .rsv_enable(rsv_enable), .rsv_adress(rsv_adress), .r15(r15), .wr_collision(wr_collision)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_p = 1'b0; wa_enable = 1'b0; wb_enable = 1'b0; rsv_enable = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        read_adress = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    // Checks reads in the current cycle, clocks once, then checks the collision flag.
    task automatic step();
        logic [DW-1:0] wm [16];
        logic [15:0]   wbs;
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          eb, ec;
        wm = mem;
        wbs = bsy;
        if (wa_enable && wa_adress != PC) wm[wa_adress] = wa_data;
        if (wb_enable && wb_adress != PC) begin
            wm[wb_adress] = wb_data;
            wbs[wb_adress] = 1'b0;
        end
        if (rsv_enable && rsv_adress != PC) wbs[rsv_adress] = 1'b1;
        #1;
        for (int p = 0; p < NR; p++) begin
            a = read_adress[p*AW +: AW];
`ifdef RF_BYPASS_EN
            ed = a == PC ? r15 : wm[a];
            eb = a != PC && wbs[a];
`else
            ed = a == PC ? r15 : mem[a];
            eb = a != PC && bsy[a];
`endif
            chk($sformatf("read_data[%0d] r%0d", p, a), read_data[p*DW +: DW], ed);
            chk($sformatf("read_busy[%0d] r%0d", p, a), DW'(read_busy[p]), DW'(eb));
        end
        ec = !rst_p && wa_enable && wb_enable && wa_adress == wb_adress && wa_adress != PC;
        @(posedge clk);
        if (rst_p) begin
            foreach (mem[k]) mem[k] = '0;
            bsy = '0;
        end else begin
            mem = wm;
            bsy = wbs;
        end
        #1;
        chk("wr_collision", DW'(wr_collision), DW'(ec));
    endtask

    initial begin
        idle();
        wa_adress = '0; wb_adress = '0; rsv_adress = '0;
        wa_data = '0; wb_data = '0; r15 = 64'h108;
        set_rd(0, 1, 2, 3);
        rst_p = 1'b1;
        @(posedge clk);
        #1;
        foreach (mem[k]) mem[k] = '0;
        bsy = '0;
        // reset wipes a written value and a reservation
        idle(); set_rd(3, 3, 4, 15);
        wa_enable = 1'b1; wa_adress = 3; wa_data = 64'hDEADBEEF;
        rsv_enable = 1'b1; rsv_adress = 4;
        step();
        idle(); step();
        rst_p = 1'b1; step();
        idle(); step();
        // PC slot ignores writes and reserves
        r15 = 64'h108; set_rd(15, 15, 15, 15);
        wa_enable = 1'b1; wa_adress = 15; wa_data = 64'h55;
        rsv_enable = 1'b1; rsv_adress = 15;
        step();
        idle(); step();
        // same-address collision: B wins, pulse for one cycle
        set_rd(5, 5, 0, 0);
        wa_enable = 1'b1; wa_adress = 5; wa_data = 64'h11;
        wb_enable = 1'b1; wb_adress = 5; wb_data = 64'h22;
        step();
        idle(); step();
        step();
        // collision on PC slot does not pulse
        wa_enable = 1'b1; wa_adress = 15; wb_enable = 1'b1; wb_adress = 15;
        step();
        idle(); step();
        // scoreboard: reserve, clear+reserve keeps busy, clear
        set_rd(7, 7, 7, 7);
        rsv_enable = 1'b1; rsv_adress = 7; step();
        idle(); step();
        wb_enable = 1'b1; wb_adress = 7; wb_data = 64'hAB;
        rsv_enable = 1'b1; rsv_adress = 7; step();
        idle(); step();
        wb_enable = 1'b1; wb_adress = 7; wb_data = 64'hAB; step();
        idle(); step();
        // reserve already busy, then reset mid-flight, then load writes normally
        rsv_enable = 1'b1; rsv_adress = 7; step();
        rsv_enable = 1'b1; step();
        idle(); rst_p = 1'b1; step();
        idle(); step();
        wb_enable = 1'b1; wb_adress = 7; wb_data = 64'hCAFE; step();
        idle(); step();
        // same-cycle read of a write target
        set_rd(2, 2, 9, 9);
        wa_enable = 1'b1; wa_adress = 2; wa_data = 64'h1234;
        wb_enable = 1'b1; wb_adress = 9; wb_data = 64'h9999; step();
        idle(); step();
        // unique 64-bit patterns in every stored slot
        for (int r = 0; r < 15; r++) begin
            wa_enable = 1'b1; wa_adress = AW'(r);
            wa_data = {32'hA5A50000 | 32'(r), ~32'(r) ^ 32'h3C3C_0000};
            set_rd(r, (r + 5) % 16, (r + 10) % 16, 15 - r);
            step();
        end
        idle();
        for (int r = 0; r < 16; r += 4) begin
            set_rd(r, r + 1, r + 2, r + 3); step();
        end
        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst_p = $urandom_range(0, 49) == 0;
            wa_enable = $urandom_range(0, 1); wb_enable = $urandom_range(0, 2) == 0;
            rsv_enable = $urandom_range(0, 2) == 0;
            wa_adress = AW'($urandom); wb_adress = $urandom_range(0, 3) == 0 ? wa_adress : AW'($urandom);
            rsv_adress = $urandom_range(0, 3) == 0 ? wb_adress : AW'($urandom);
            wa_data = {$urandom, $urandom}; wb_data = {$urandom, $urandom}; r15 = {$urandom, $urandom};
            read_adress = NR*AW'($urandom);
            if ($urandom_range(0, 3) == 0) read_adress[AW-1:0] = wb_adress;
            if ($urandom_range(0, 3) == 0) read_adress[2*AW-1:AW] = wa_adress;
            step();
        end
        idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
